c2_bus_initiator: RTL

Cache-side master for the C2 memory bus. It accepts one line-sized read (fill) or write (writeback) request from the cache controller and serializes it onto the shared command/address/data lines. It then waits for the memory's `C2_RESPONSE` and returns the line, or a write completion, to the cache. It sits between the cache controller and the main-memory model. Tristate resolution of the shared lines happens at the top level, using `c2_drive`.

---
 rtl/c2_bus_initiator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/c2_bus_initiator.sv
// Cache-side C2 bus master: serializes one line fill or writeback onto the shared
// command/address/data lines. It then collects the memory response and returns a
// one-cycle completion to the cache. The top level resolves the shared lines using c2_drive.
module c2_bus_initiator #(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned LINE_BYTES        = 1 << CACHE_OFFSET_SIZE,
  parameter int unsigned BUS_BYTES         = 2,
  parameter int unsigned BEATS             = LINE_BYTES / BUS_BYTES,
  parameter int unsigned TIMEOUT           = 255
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic                                       req_write,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
  input  logic [8*LINE_BYTES-1:0]                    req_wdata,
  output logic                                       rsp_valid,
  output logic                                       rsp_err,
  output logic [8*LINE_BYTES-1:0]                    rsp_rdata,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] c2_addr,
  output logic [1:0]                                 c2_cmd_out,
  input  logic [1:0]                                 c2_cmd_in,
  output logic [8*BUS_BYTES-1:0]                     c2_data_out,
  input  logic [8*BUS_BYTES-1:0]                     c2_data_in,
  output logic                                       c2_drive
);

  localparam int unsigned BW    = 8 * BUS_BYTES;
  localparam int unsigned LW    = 8 * LINE_BYTES;
  localparam int unsigned BeatW = $clog2(BEATS);

  localparam logic [BeatW-1:0] LastBeat   = BeatW'(BEATS - 1);
  localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    CmdNop      = 2'd0,
    CmdResponse = 2'd1,
    CmdRead     = 2'd2,
    CmdWrite    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StSendWr,
    StSendRd,
    StWaitRsp,
    StRecvRd,
    StDone
  } state_e;

  state_e           state_q;
  logic             write_q;
  logic [LW-1:0]    wdata_q;
  logic [LW-1:0]    rx_q;
  logic [BeatW-1:0] beat_q;
  logic [7:0]       tmo_q;

  logic [BeatW-1:0] beat_inc;
  logic [LW-1:0]    rx_merged;

  // Next beat index, and the receive buffer with the current bus beat dropped in place
  always_comb begin
    beat_inc  = beat_q + BeatW'(1);
    rx_merged = rx_q;
    rx_merged[BW*int'(beat_q) +: BW] = c2_data_in;
  end

  // Transfer sequencer; all bus and cache-side outputs are registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      c2_addr     <= '0;
      c2_cmd_out  <= CmdNop;
      c2_data_out <= '0;
      c2_drive    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rx_q        <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            beat_q    <= '0;
            tmo_q     <= '0;
            c2_addr   <= req_addr;
            c2_drive  <= 1'b1;
            if (req_write) begin
              state_q     <= StSendWr;
              c2_cmd_out  <= CmdWrite;
              c2_data_out <= req_wdata[BW-1:0];
            end else begin
              state_q    <= StSendRd;
              c2_cmd_out <= CmdRead;
            end
          end
        end

        StSendRd: begin
          state_q    <= StWaitRsp;
          c2_drive   <= 1'b0;
          c2_cmd_out <= CmdNop;
        end

        StSendWr: begin
          if (beat_q == LastBeat) begin
            state_q     <= StWaitRsp;
            c2_drive    <= 1'b0;
            c2_cmd_out  <= CmdNop;
            c2_data_out <= '0;
          end else begin
            beat_q      <= beat_inc;
            c2_data_out <= wdata_q[BW*int'(beat_inc) +: BW];
          end
        end

        StWaitRsp: begin
          if (c2_cmd_in == CmdResponse) begin
            if (write_q) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              // The first response beat arrives in this state, so it is captured here
              rx_q[BW-1:0] <= c2_data_in;
              beat_q       <= BeatW'(1);
              state_q      <= StRecvRd;
            end
          end else if (tmo_q == TimeoutCnt) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (tmo_q != 8'hFF) begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        StRecvRd: begin
          if (c2_cmd_in == CmdResponse) begin
            rx_q <= rx_merged;
            if (beat_q == LastBeat) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rx_merged;
            end else begin
              beat_q <= beat_inc;
            end
          end else begin
            // Broken burst: report an error and keep the previous line in rsp_rdata
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end

        StDone: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
        end

        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          c2_drive  <= 1'b0;
        end
      endcase
    end
  end

endmodule
